// File: rtl/aoc_c8_pkg.sv
// -----------------------------------------------------------------------------
// aoc_c8_pkg
// Shared types for the pair scheduler: default sizing, index / coordinate /
// pair-count types for the default configuration, the scheduler FSM state
// encoding and a width helper that never returns zero.
// -----------------------------------------------------------------------------
package aoc_c8_pkg;

    localparam int NUM_POINTS_DEF = 1000;
    localparam int DIM_W_DEF      = 17;

    // $clog2 returns 0 for 0/1; a zero-width vector is illegal, so floor at 1.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    localparam int IDX_W_DEF = clog2_min1(NUM_POINTS_DEF);
    localparam int CNT_W_DEF = clog2_min1(NUM_POINTS_DEF * (NUM_POINTS_DEF - 1) / 2 + 1);

    typedef logic [IDX_W_DEF-1:0]   point_idx_t;
    typedef logic [3*DIM_W_DEF-1:0] coord_t;
    typedef logic [CNT_W_DEF-1:0]   pair_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pair_iter.sv
// -----------------------------------------------------------------------------
// pair_iter
// Walks the unordered index pairs (i,j), i<j<n, in row order:
// (0,1),(0,2)..(0,n-1),(1,2)..(n-2,n-1).
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      restart at (0,1) and capture the point count n_i
//   n_i         point count for the run (already clamped by the caller)
//   step_i      advance to the next pair
//   i_o, j_o    current pair
//   last_o      current pair is (n-2,n-1)
// -----------------------------------------------------------------------------
module pair_iter #(
    parameter int IDX_W = 10,
    parameter int NUM_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [NUM_W-1:0] n_i,
    input  logic             step_i,
    output logic [IDX_W-1:0] i_o,
    output logic [IDX_W-1:0] j_o,
    output logic             last_o
);

    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [NUM_W-1:0] n_q, n_d;
    logic             j_at_end;

    // The count is at least as wide as an index, so widening is lossless.
    assign j_at_end = (NUM_W'(j_q) == n_q - NUM_W'(1));
    assign last_o   = j_at_end && (NUM_W'(i_q) == n_q - NUM_W'(2));
    assign i_o      = i_q;
    assign j_o      = j_q;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        i_d = i_q;
        j_d = j_q;
        n_d = n_q;
        if (load_i) begin
            i_d = '0;
            j_d = IDX_W'(1);
            n_d = n_i;
        end else if (step_i) begin
            if (!j_at_end) begin
                j_d = j_q + IDX_W'(1);
            end else begin
                // Row finished: next row starts just right of the new diagonal.
                i_d = i_q + IDX_W'(1);
                j_d = i_q + IDX_W'(2);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            n_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            n_q <= n_d;
        end
    end

endmodule

// File: rtl/pair_sched.sv
// -----------------------------------------------------------------------------
// pair_sched
// Issues every unordered point pair of a run to a dual-read coordinate RAM and
// presents the pair tags plus the returned coordinates on a valid/ready
// interface towards the distance/sorter path.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, num_pts             begin a run over num_pts points (clamped)
//   ram_addr_a/b, ram_rd_en    RAM read request; RAM output valid next cycle
//   ram_data_a/b               RAM {x,y,z} read data
//   pointa_out, pointb_out     pair tags aligned with coord_a/b
//   coord_a, coord_b           RAM data passed straight through
//   pair_vld, pair_rdy         output handshake
//   busy, done                 run in progress / one-cycle completion pulse
//   pair_cnt                   pairs accepted during the current run
//
// Build option
//   PAIR_SCHED_ABORT_EN        adds input abort: drops the run from RUN/DRAIN
//                              back to IDLE with no done pulse
// -----------------------------------------------------------------------------
module pair_sched
    import aoc_c8_pkg::*;
#(
    parameter  int NUM_POINTS = NUM_POINTS_DEF,
    parameter  int DIM_W      = DIM_W_DEF,
    localparam int IDX_W      = clog2_min1(NUM_POINTS),
    localparam int NUM_W      = clog2_min1(NUM_POINTS + 1),
    localparam int CNT_W      = clog2_min1(NUM_POINTS * (NUM_POINTS - 1) / 2 + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_W-1:0]   num_pts,
    output logic [IDX_W-1:0]   ram_addr_a,
    output logic [IDX_W-1:0]   ram_addr_b,
    output logic               ram_rd_en,
    input  logic [3*DIM_W-1:0] ram_data_a,
    input  logic [3*DIM_W-1:0] ram_data_b,
    output logic [IDX_W-1:0]   pointa_out,
    output logic [IDX_W-1:0]   pointb_out,
    output logic [3*DIM_W-1:0] coord_a,
    output logic [3*DIM_W-1:0] coord_b,
    output logic               pair_vld,
    input  logic               pair_rdy,
`ifdef PAIR_SCHED_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pair_cnt
);

    state_e           state_q, state_d;
    logic             pair_vld_q;
    logic [IDX_W-1:0] tag_a_q, tag_b_q;
    logic [CNT_W-1:0] pair_cnt_q;

    logic             issue;
    logic             load;
    logic             cnt_clr;
    logic             accept;
    logic             adv;
    logic             abort_w;
    logic             iter_last;
    logic [IDX_W-1:0] iter_i, iter_j;
    logic [NUM_W-1:0] n_eff;

    assign n_eff = (int'(num_pts) > NUM_POINTS) ? NUM_W'(NUM_POINTS) : num_pts;

    // A new pair may be issued when the output slot is empty or being drained.
    assign accept = pair_vld_q && pair_rdy;
    assign adv    = !pair_vld_q || pair_rdy;

`ifdef PAIR_SCHED_ABORT_EN
    assign abort_w = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
`else
    assign abort_w = 1'b0;
`endif

    pair_iter #(
        .IDX_W (IDX_W),
        .NUM_W (NUM_W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .n_i    (n_eff),
        // Freeze on the last pair so the address never walks past the run.
        .step_i (issue && !iter_last),
        .i_o    (iter_i),
        .j_o    (iter_j),
        .last_o (iter_last)
    );

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        load    = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = (int'(n_eff) >= 2) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                issue = adv;
                if (adv && iter_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_w) begin
            state_d = ST_IDLE;
            issue   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pair_vld_q <= 1'b0;
            tag_a_q    <= '0;
            tag_b_q    <= '0;
            pair_cnt_q <= '0;
        end else begin
            state_q <= state_d;

            if (abort_w) begin
                pair_vld_q <= 1'b0;
            end else if (issue) begin
                pair_vld_q <= 1'b1;
            end else if (accept) begin
                pair_vld_q <= 1'b0;
            end

            // Tags follow the RAM read by one cycle, matching RAM latency.
            if (issue) begin
                tag_a_q <= iter_i;
                tag_b_q <= iter_j;
            end

            if (cnt_clr) begin
                pair_cnt_q <= '0;
            end else if (accept && !abort_w) begin
                pair_cnt_q <= pair_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ram_addr_a = iter_i;
    assign ram_addr_b = iter_j;
    assign ram_rd_en  = issue;
    assign pointa_out = tag_a_q;
    assign pointb_out = tag_b_q;
    // The RAM holds its outputs while ram_rd_en is low, so stalls stay stable.
    assign coord_a    = ram_data_a;
    assign coord_b    = ram_data_b;
    assign pair_vld   = pair_vld_q;
    assign pair_cnt   = pair_cnt_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_pair_sched.sv
// -----------------------------------------------------------------------------
// tb_pair_sched
// Self-checking bench for pair_sched. A small NUM_POINTS keeps the full-size
// and clamped runs short. The expected pair sequence is generated with nested
// loops over i<j<n and consumed in order as pairs are accepted.
// -----------------------------------------------------------------------------
module tb_pair_sched;

    localparam int NP    = 40;
    localparam int DW    = 17;
    localparam int IDX_W = $clog2(NP);
    localparam int NUM_W = $clog2(NP + 1);
    localparam int CNT_W = $clog2(NP * (NP - 1) / 2 + 1);

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [NUM_W-1:0]   num_pts;
    logic [IDX_W-1:0]   ram_addr_a, ram_addr_b;
    logic               ram_rd_en;
    logic [3*DW-1:0]    ram_data_a, ram_data_b;
    logic [IDX_W-1:0]   pointa_out, pointb_out;
    logic [3*DW-1:0]    coord_a, coord_b;
    logic               pair_vld;
    logic               pair_rdy;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   pair_cnt;
`ifdef PAIR_SCHED_ABORT_EN
    logic               abort;
`endif

    logic [3*DW-1:0]    mem [NP];

    int n_checks = 0;
    int n_fail   = 0;

    pair_sched #(
        .NUM_POINTS (NP),
        .DIM_W      (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_pts    (num_pts),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_rd_en  (ram_rd_en),
        .ram_data_a (ram_data_a),
        .ram_data_b (ram_data_b),
        .pointa_out (pointa_out),
        .pointb_out (pointb_out),
        .coord_a    (coord_a),
        .coord_b    (coord_b),
        .pair_vld   (pair_vld),
        .pair_rdy   (pair_rdy),
`ifdef PAIR_SCHED_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .pair_cnt   (pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-read RAM model: one-cycle latency, holds outputs when not read.
    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_data_a <= mem[ram_addr_a];
            ram_data_b <= mem[ram_addr_b];
        end
    end

    function automatic logic pick_rdy(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            default: return 1'(($urandom % 3) != 0);
        endcase
    endfunction

    // One full run: start, watch every cycle until done, compare against the
    // ordered list of expected pairs. mode: 0 ready always, 1 toggle, 2 random.
    task automatic run_pairs(input int n_req, input int mode, input bit poke, input string name);
        int n, total, got, dones, cyc, first_acc, last_acc, budget, ea, eb;
        int exp_a[$];
        int exp_b[$];
        bit stall_prev, finished;
        logic [IDX_W-1:0] sv_a, sv_b;
        logic [3*DW-1:0]  sv_ca, sv_cb;

        n = (n_req > NP) ? NP : n_req;
        for (int a = 0; a < n; a++) begin
            for (int b = a + 1; b < n; b++) begin
                exp_a.push_back(a);
                exp_b.push_back(b);
            end
        end
        total      = exp_a.size();
        budget     = 4 * total + 20;
        got        = 0;
        dones      = 0;
        first_acc  = -1;
        last_acc   = -1;
        stall_prev = 1'b0;
        finished   = 1'b0;
        sv_a = '0; sv_b = '0; sv_ca = '0; sv_cb = '0;

        @(negedge clk);
        num_pts  = NUM_W'(n_req);
        start    = 1'b1;
        pair_rdy = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        num_pts = NUM_W'($urandom);   // must be ignored mid-run

        n_checks++;
        if (busy !== (n >= 2)) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b expected %b", name, busy, n >= 2);
        end

        for (cyc = 0; cyc < budget && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = poke && (cyc == 3);

            n_checks++;
            if (pair_cnt !== got) begin
                n_fail++;
                $display("FAIL %s pair_cnt cyc%0d: got %0d expected %0d", name, cyc, pair_cnt, got);
            end

            if (stall_prev) begin
                n_checks++;
                if (pointa_out !== sv_a || pointb_out !== sv_b || coord_a !== sv_ca || coord_b !== sv_cb
                    || pair_vld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s stall_hold cyc%0d: got (%0d,%0d) vld=%b expected (%0d,%0d) held",
                             name, cyc, pointa_out, pointb_out, pair_vld, sv_a, sv_b);
                end
            end

            if (done === 1'b1) begin
                dones++;
                finished = 1'b1;
                n_checks++;
                if (got != total) begin
                    n_fail++;
                    $display("FAIL %s done_early: got %0d pairs expected %0d", name, got, total);
                end
                if (n < 2) begin
                    n_checks++;
                    if (cyc != 0) begin
                        n_fail++;
                        $display("FAIL %s done_latency: got cycle %0d expected 0", name, cyc);
                    end
                end
            end

            pair_rdy = pick_rdy(mode, cyc);

            if (pair_vld === 1'b1 && pair_rdy) begin
                n_checks++;
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_pair: got (%0d,%0d) expected none", name, pointa_out, pointb_out);
                end else begin
                    ea = exp_a.pop_front();
                    eb = exp_b.pop_front();
                    if (pointa_out !== IDX_W'(ea) || pointb_out !== IDX_W'(eb)) begin
                        n_fail++;
                        $display("FAIL %s pair_tag #%0d: got (%0d,%0d) expected (%0d,%0d)",
                                 name, got, pointa_out, pointb_out, ea, eb);
                    end
                    n_checks++;
                    if (coord_a !== mem[ea] || coord_b !== mem[eb]) begin
                        n_fail++;
                        $display("FAIL %s pair_coord #%0d: got %h/%h expected %h/%h",
                                 name, got, coord_a, coord_b, mem[ea], mem[eb]);
                    end
                    got++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            end

            stall_prev = (pair_vld === 1'b1) && !pair_rdy;
            sv_a  = pointa_out;
            sv_b  = pointb_out;
            sv_ca = coord_a;
            sv_cb = coord_b;
        end

        start = 1'b0;
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s timeout: got no done within %0d cycles expected done", name, budget);
        end

        @(negedge clk);
        pair_rdy = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, done, busy);
        end
        n_checks++;
        if (got != total || exp_a.size() != 0) begin
            n_fail++;
            $display("FAIL %s pair_total: got %0d expected %0d", name, got, total);
        end
        n_checks++;
        if (pair_cnt !== total) begin
            n_fail++;
            $display("FAIL %s final_pair_cnt: got %0d expected %0d", name, pair_cnt, total);
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d expected 1", name, dones);
        end
        if (mode == 0 && total > 0) begin
            n_checks++;
            if (last_acc - first_acc != total - 1) begin
                n_fail++;
                $display("FAIL %s back_to_back: got span %0d expected %0d", name, last_acc - first_acc, total - 1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (pair_vld !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || ram_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ctrl: got vld=%b done=%b busy=%b rd=%b expected all 0",
                     name, pair_vld, done, busy, ram_rd_en);
        end
        n_checks++;
        if (pointa_out !== '0 || pointb_out !== '0 || ram_addr_a !== '0 || ram_addr_b !== '0
            || pair_cnt !== '0) begin
            n_fail++;
            $display("FAIL %s idx: got tags (%0d,%0d) addr (%0d,%0d) cnt %0d expected all 0",
                     name, pointa_out, pointb_out, ram_addr_a, ram_addr_b, pair_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        num_pts  = NUM_W'(5);
        start    = 1'b1;
        pair_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = (pair_vld === 1'b1) && (pointa_out == 1) && (pointb_out == 2);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_reset reach_pair: got no (1,2) expected (1,2) within 30 cycles");
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        pair_rdy = 1'b0;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset done_pulse: got %b expected 0", done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset_release");
        run_pairs(3, 0, 1'b0, "after_reset_n3");
    endtask

`ifdef PAIR_SCHED_ABORT_EN
    task automatic test_abort();
        bit seen;
        int dones;
        seen  = 1'b0;
        dones = 0;
        @(negedge clk);
        num_pts  = NUM_W'(6);
        start    = 1'b1;
        pair_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = (pair_vld === 1'b1) && (pointa_out == 0) && (pointb_out == 3);
        end
        n_checks++;
        if (!seen || pair_cnt !== 2) begin
            n_fail++;
            $display("FAIL abort third_pair: got seen=%b cnt=%0d expected 1/2", seen, pair_cnt);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || pair_vld !== 1'b0 || pair_cnt !== 2) begin
            n_fail++;
            $display("FAIL abort state: got busy=%b vld=%b cnt=%0d expected 0/0/2", busy, pair_vld, pair_cnt);
        end
        for (int k = 0; k < 5; k++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        pair_rdy = 1'b0;
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort no_done: got %0d pulses expected 0", dones);
        end
    endtask
`endif

    initial begin
        start    = 1'b0;
        num_pts  = '0;
        pair_rdy = 1'b0;
        rst_n    = 1'b0;
`ifdef PAIR_SCHED_ABORT_EN
        abort    = 1'b0;
`endif
        for (int k = 0; k < NP; k++) begin
            mem[k] = {17'($urandom), 17'($urandom), 17'($urandom)};
        end

        test_reset();
        run_pairs(4, 0, 1'b0, "basic_n4");
        run_pairs(5, 1, 1'b1, "toggle_n5");
        run_pairs(1, 2, 1'b0, "short_n1");
        run_pairs(0, 0, 1'b0, "short_n0");
        run_pairs(NP, 2, 1'b0, "full_np");
        run_pairs(63, 0, 1'b0, "clamp_63");
        run_pairs(2, 2, 1'b0, "min_n2");
        for (int r = 0; r < 4; r++) begin
            run_pairs(int'($urandom_range(2, 12)), 2, 1'b0, "random_n");
        end
        test_reset_mid_run();
`ifdef PAIR_SCHED_ABORT_EN
        test_abort();
        run_pairs(4, 0, 1'b0, "after_abort_n4");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
